// File: rtl/micro_seq_pkg.sv
// Shared state, trap-cause and microaddress constants for the micro_sequencer slice.
package micro_seq_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    RUN      = 2'd2,
    TRAP     = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    TRAP_NONE   = 2'd0,
    TRAP_UNSUP  = 2'd1,
    TRAP_BADROM = 2'd2,
    TRAP_STEPS  = 2'd3
  } trap_code_e;

  // Width-agnostic: cast to ADR_W at the use site (-1 becomes all ones).
  localparam int UADR_END     = 0;
  localparam int UADR_INVALID = -1;

endpackage

// File: rtl/micro_sequencer_if.sv
// Opcode intake, next-address ROM and micro-op emitter bus of the micro_sequencer.
interface micro_sequencer_if #(
  parameter int ADR_W = 9,
  parameter int OPC_W = 8
);
  logic             bc_valid;
  logic             bc_ready;
  logic [OPC_W-1:0] bc_opcode;
  logic [ADR_W-1:0] rom_adr;
  logic [ADR_W-1:0] rom_next;
  logic             uop_valid;
  logic             uop_ready;
  logic [ADR_W-1:0] uop_adr;

  modport master (
    output bc_valid, bc_opcode, rom_next, uop_ready,
    input  bc_ready, rom_adr, uop_valid, uop_adr
  );

  modport slave (
    input  bc_valid, bc_opcode, rom_next, uop_ready,
    output bc_ready, rom_adr, uop_valid, uop_adr
  );
endinterface

// File: rtl/micro_seq_step_cnt.sv
// Saturating per-opcode step counter; flags the last permitted microaddress.
module micro_seq_step_cnt #(
  parameter int MAX_STEPS = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);
  localparam int CNT_W = $clog2(MAX_STEPS + 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(MAX_STEPS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_STEPS - 1);

  logic [CNT_W-1:0] cnt_r;

  // Count handshakes, holding at MAX_STEPS instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (inc && (cnt_r != CNT_SAT)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign at_limit = (cnt_r == CNT_LAST);
endmodule

// File: rtl/micro_sequencer.sv
// Microcode sequencer: dispatches an opcode through the external next-address ROM and walks the chain.
// Optional MICRO_SEQUENCER_PERF_EN adds perf_clr, perf_bc_cnt and perf_uop_cnt.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int ADR_W     = 9,
  parameter int OPC_W     = 8,
  parameter int MAX_STEPS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  micro_sequencer_if.slave bus,
  output logic             done,
  output logic             trap,
  output logic [1:0]       trap_code,
  output logic [OPC_W-1:0] trap_opcode,
  input  logic             trap_clr,
  output logic             busy
`ifdef MICRO_SEQUENCER_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [31:0]      perf_bc_cnt,
  output logic [31:0]      perf_uop_cnt
`endif
);
  localparam logic [ADR_W-1:0] ADR_END = ADR_W'(UADR_END);
  localparam logic [ADR_W-1:0] ADR_INV = ADR_W'(UADR_INVALID);

  seq_state_e       state_r, state_nxt_s;
  trap_code_e       trap_code_r, trap_code_nxt_s;
  logic [OPC_W-1:0] opcode_r, trap_opcode_r;
  logic [ADR_W-1:0] upc_r;
  logic             done_r, trap_r;
  logic             accept_s, upc_ld_s, cnt_inc_s, done_set_s, trap_set_s, trap_clr_s;
  logic             next_end_s, next_inv_s, at_limit_s;

  assign next_end_s = (bus.rom_next == ADR_END);
  assign next_inv_s = (bus.rom_next == ADR_INV);

  micro_seq_step_cnt #(.MAX_STEPS(MAX_STEPS)) u_step_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (accept_s),
    .inc      (cnt_inc_s),
    .at_limit (at_limit_s)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state and datapath strobes; in RUN the ROM result decides in end/invalid/limit order
  always_comb begin
    state_nxt_s     = state_r;
    accept_s        = 1'b0;
    upc_ld_s        = 1'b0;
    cnt_inc_s       = 1'b0;
    done_set_s      = 1'b0;
    trap_set_s      = 1'b0;
    trap_clr_s      = 1'b0;
    trap_code_nxt_s = TRAP_NONE;
    case (state_r)
      IDLE: begin
        if (bus.bc_valid) begin
          accept_s    = 1'b1;
          state_nxt_s = DISPATCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      DISPATCH: begin
        if (next_end_s) begin
          trap_set_s = 1'b1; trap_code_nxt_s = TRAP_UNSUP;  state_nxt_s = TRAP;
        end else if (next_inv_s) begin
          trap_set_s = 1'b1; trap_code_nxt_s = TRAP_BADROM; state_nxt_s = TRAP;
        end else begin
          upc_ld_s = 1'b1; state_nxt_s = RUN;
        end
      end
      RUN: begin
        if (!bus.uop_ready) begin
          state_nxt_s = RUN;
        end else if (next_end_s) begin
          done_set_s = 1'b1; state_nxt_s = IDLE;
        end else if (next_inv_s) begin
          trap_set_s = 1'b1; trap_code_nxt_s = TRAP_BADROM; state_nxt_s = TRAP;
        end else if (at_limit_s) begin
          trap_set_s = 1'b1; trap_code_nxt_s = TRAP_STEPS;  state_nxt_s = TRAP;
        end else begin
          upc_ld_s = 1'b1; cnt_inc_s = 1'b1; state_nxt_s = RUN;
        end
      end
      TRAP: begin
        if (trap_clr) begin
          trap_clr_s = 1'b1; state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TRAP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Opcode latch, uPC, done pulse and sticky trap record
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_r      <= {OPC_W{1'b0}};
      upc_r         <= {ADR_W{1'b0}};
      done_r        <= 1'b0;
      trap_r        <= 1'b0;
      trap_code_r   <= TRAP_NONE;
      trap_opcode_r <= {OPC_W{1'b0}};
    end else begin
      done_r <= done_set_s;
      if (accept_s) opcode_r <= bus.bc_opcode;
      if (upc_ld_s) upc_r <= bus.rom_next;
      if (trap_set_s) begin
        trap_r        <= 1'b1;
        trap_code_r   <= trap_code_nxt_s;
        trap_opcode_r <= opcode_r;
      end else if (trap_clr_s) begin
        trap_r        <= 1'b0;
        trap_code_r   <= TRAP_NONE;
        trap_opcode_r <= {OPC_W{1'b0}};
      end
    end
  end

  // ROM address decoded from registered state only, never from bc_opcode
  always_comb begin
    case (state_r)
      DISPATCH: bus.rom_adr = ADR_W'(opcode_r);
      RUN:      bus.rom_adr = upc_r;
      default:  bus.rom_adr = {ADR_W{1'b0}};
    endcase
  end

  assign bus.bc_ready  = (state_r == IDLE);
  assign bus.uop_valid = (state_r == RUN);
  assign bus.uop_adr   = upc_r;
  assign busy          = (state_r != IDLE);
  assign done          = done_r;
  assign trap          = trap_r;
  assign trap_code     = trap_code_r;
  assign trap_opcode   = trap_opcode_r;

`ifdef MICRO_SEQUENCER_PERF_EN
  logic hs_s;
  assign hs_s = (state_r == RUN) && bus.uop_ready;

  // Free-running completion and handshake counters; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bc_cnt  <= 32'd0;
      perf_uop_cnt <= 32'd0;
    end else if (perf_clr) begin
      perf_bc_cnt  <= 32'd0;
      perf_uop_cnt <= 32'd0;
    end else begin
      if (done_set_s) perf_bc_cnt <= perf_bc_cnt + 32'd1;
      if (hs_s) perf_uop_cnt <= perf_uop_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_micro_sequencer.sv
// Self-checking bench for micro_sequencer: directed scenarios plus random ROM chains vs a chain-walk model.
module tb_micro_sequencer;
  localparam int MAX_STEPS = 32;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       done, trap, trap_clr, busy;
  logic [1:0] trap_code;
  logic [7:0] trap_opcode;
`ifdef MICRO_SEQUENCER_PERF_EN
  logic        perf_clr;
  logic [31:0] perf_bc_cnt, perf_uop_cnt;
`endif

  micro_sequencer_if #(.ADR_W(9), .OPC_W(8)) bus ();

  micro_sequencer #(.ADR_W(9), .OPC_W(8), .MAX_STEPS(MAX_STEPS)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .done(done), .trap(trap), .trap_code(trap_code),
    .trap_opcode(trap_opcode), .trap_clr(trap_clr), .busy(busy)
`ifdef MICRO_SEQUENCER_PERF_EN
    , .perf_clr(perf_clr), .perf_bc_cnt(perf_bc_cnt), .perf_uop_cnt(perf_uop_cnt)
`endif
  );

  always #5 clk = ~clk;

  logic [8:0] rom_mem [0:511];
  assign bus.rom_next = rom_mem[bus.rom_adr];

  int total = 0;
  int bad   = 0;

  // run_op observations
  logic [8:0] obs_q[$];
  bit got_done, got_trap, timeout, start_rdy, rdy_at_end;
  int first_vld, done_cyc, stall_bad, stall_cnt, bad_adr;
  // model expectations
  logic [8:0] exp_q[$];
  bit exp_done;
  logic [1:0] exp_code;

  // Reference: walk the ROM chain by the sequencing rules
  function automatic void model_walk(input logic [7:0] opc);
    logic [8:0] a, n;
    bit walking;
    exp_q.delete(); exp_done = 1'b0; exp_code = 2'd0;
    a = rom_mem[{1'b0, opc}];
    walking = 1'b1;
    if (a == 9'd0) begin exp_code = 2'd1; walking = 1'b0; end
    else if (a == 9'h1FF) begin exp_code = 2'd2; walking = 1'b0; end
    while (walking) begin
      exp_q.push_back(a);
      n = rom_mem[a];
      if (n == 9'd0) begin exp_done = 1'b1; walking = 1'b0; end
      else if (n == 9'h1FF) begin exp_code = 2'd2; walking = 1'b0; end
      else if (exp_q.size() == MAX_STEPS) begin exp_code = 2'd3; walking = 1'b0; end
      else a = n;
    end
  endfunction

  // Offer one opcode at a negedge and observe until done/trap; pct<0 toggles uop_ready
  task automatic run_op(input logic [7:0] opc, input int pct, input int budget);
    logic [8:0] prev_adr;
    bit prev_stall;
    int cyc;
    prev_adr = 9'd0; prev_stall = 1'b0; cyc = 0;
    obs_q.delete(); got_done = 1'b0; got_trap = 1'b0; timeout = 1'b0; rdy_at_end = 1'b0;
    first_vld = -1; done_cyc = -1; stall_bad = 0; stall_cnt = 0; bad_adr = 0;
    start_rdy = bus.bc_ready;
    bus.bc_valid = 1'b1; bus.bc_opcode = opc; bus.uop_ready = 1'b0;
    @(negedge clk);
    bus.bc_valid = 1'b0;
    while (1) begin
      if (prev_stall && (!bus.uop_valid || bus.uop_adr !== prev_adr)) stall_bad++;
      if (bus.uop_valid && first_vld < 0) first_vld = cyc;
      if (done) begin got_done = 1'b1; done_cyc = cyc; rdy_at_end = bus.bc_ready; break; end
      if (trap) begin got_trap = 1'b1; break; end
      if (cyc >= budget) begin timeout = 1'b1; break; end
      bus.uop_ready = (pct < 0) ? ~bus.uop_ready : ($urandom_range(0, 99) < pct);
      if (bus.uop_valid && bus.uop_ready) begin
        obs_q.push_back(bus.uop_adr);
        if (bus.uop_adr == 9'd0 || bus.uop_adr == 9'h1FF) bad_adr++;
      end
      prev_stall = bus.uop_valid && !bus.uop_ready;
      if (prev_stall) stall_cnt++;
      prev_adr = bus.uop_adr;
      @(negedge clk);
      cyc++;
    end
    bus.uop_ready = 1'b0;
  endtask

  task automatic clear_trap();
    trap_clr = 1'b1;
    @(negedge clk);
    trap_clr = 1'b0;
  endtask

  task automatic test_reset();
    logic [24:0] got, want;
    want = {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0};
    got = {bus.bc_ready, bus.uop_valid, bus.uop_adr, done, trap, trap_code, trap_opcode, busy, |bus.rom_adr};
    total++; if (got !== want) begin bad++; $display("FAIL reset_vals: got %h want %h", got, want); end
    rst_n = 1'b1;
    @(negedge clk);
    got = {bus.bc_ready, bus.uop_valid, bus.uop_adr, done, trap, trap_code, trap_opcode, busy, |bus.rom_adr};
    total++; if (got !== want) begin bad++; $display("FAIL idle_vals: got %h want %h", got, want); end
  endtask

  task automatic test_iadd();
    run_op(8'h60, 100, 50);
    total++; if (start_rdy !== 1'b1) begin bad++; $display("FAIL iadd_ready: got %0b want 1", start_rdy); end
    total++; if (timeout !== 1'b0 || got_done !== 1'b1) begin bad++; $display("FAIL iadd_done: got done=%0b timeout=%0b want 1/0", got_done, timeout); end
    total++; if (first_vld !== 1) begin bad++; $display("FAIL iadd_first_valid: got N+%0d want N+2", first_vld + 1); end
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL iadd_len: got %0d want 2", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== 9'd256 || obs_q[1] !== 9'd257) begin bad++; $display("FAIL iadd_seq: got %0d,%0d want 256,257", obs_q[0], obs_q[1]); end
    end
    total++; if (done_cyc !== 3 || rdy_at_end !== 1'b1) begin bad++; $display("FAIL iadd_done_cycle: got N+%0d ready=%0b want N+4 ready=1", done_cyc + 1, rdy_at_end); end
    @(negedge clk);
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL iadd_done_pulse: got done=%0b busy=%0b want 0/0", done, busy); end
  endtask

  task automatic test_isub_stall();
    run_op(8'h64, -1, 50);
    total++; if (got_done !== 1'b1) begin bad++; $display("FAIL isub_done: got %0b want 1", got_done); end
    total++; if (stall_cnt < 1 || stall_bad !== 0) begin bad++; $display("FAIL isub_stall: got stalls=%0d unstable=%0d want >0/0", stall_cnt, stall_bad); end
    total++; if (obs_q.size() !== 2) begin bad++; $display("FAIL isub_len: got %0d want 2", obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== 9'd258 || obs_q[1] !== 9'd257) begin bad++; $display("FAIL isub_seq: got %0d,%0d want 258,257", obs_q[0], obs_q[1]); end
    end
  endtask

  task automatic test_unsup();
    run_op(8'h00, 100, 50);
    total++; if (got_trap !== 1'b1 || trap_code !== 2'd1 || trap_opcode !== 8'h00) begin bad++; $display("FAIL unsup_trap: got trap=%0b code=%0d opc=%h want 1/1/00", got_trap, trap_code, trap_opcode); end
    total++; if (first_vld !== -1 || bus.bc_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL unsup_quiet: got first_valid=%0d ready=%0b busy=%0b want -1/0/1", first_vld, bus.bc_ready, busy); end
    @(negedge clk);
    total++; if (trap !== 1'b1 || trap_code !== 2'd1) begin bad++; $display("FAIL unsup_sticky: got trap=%0b code=%0d want 1/1", trap, trap_code); end
    clear_trap();
    total++; if (trap !== 1'b0 || trap_code !== 2'd0 || bus.bc_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL unsup_clear: got trap=%0b code=%0d ready=%0b busy=%0b want 0/0/1/0", trap, trap_code, bus.bc_ready, busy); end
  endtask

  task automatic test_badrom();
    logic [8:0] saved;
    saved = rom_mem[9'h060];
    rom_mem[9'h060] = 9'h1FF;
    run_op(8'h60, 100, 50);
    total++; if (got_trap !== 1'b1 || trap_code !== 2'd2 || trap_opcode !== 8'h60 || first_vld !== -1) begin bad++; $display("FAIL badrom_trap: got trap=%0b code=%0d opc=%h fv=%0d want 1/2/60/-1", got_trap, trap_code, trap_opcode, first_vld); end
    clear_trap();
    rom_mem[9'h060] = saved;
  endtask

  task automatic test_steps();
    bit all_same;
    rom_mem[9'h070] = 9'd300;
    rom_mem[9'd300] = 9'd300;
    run_op(8'h70, 100, 200);
    total++; if (got_trap !== 1'b1 || trap_code !== 2'd3 || trap_opcode !== 8'h70) begin bad++; $display("FAIL steps_trap: got trap=%0b code=%0d opc=%h want 1/3/70", got_trap, trap_code, trap_opcode); end
    all_same = 1'b1;
    foreach (obs_q[i]) if (obs_q[i] !== 9'd300) all_same = 1'b0;
    total++; if (obs_q.size() !== MAX_STEPS || !all_same) begin bad++; $display("FAIL steps_count: got %0d uops same=%0b want %0d/1", obs_q.size(), all_same, MAX_STEPS); end
    clear_trap();
  endtask

`ifdef MICRO_SEQUENCER_PERF_EN
  task automatic test_perf();
    perf_clr = 1'b1; @(negedge clk); perf_clr = 1'b0;
    total++; if (perf_bc_cnt !== 32'd0 || perf_uop_cnt !== 32'd0) begin bad++; $display("FAIL perf_clr0: got %0d/%0d want 0/0", perf_bc_cnt, perf_uop_cnt); end
    run_op(8'h60, 100, 50);
    run_op(8'h64, 60, 300);
    @(negedge clk);
    total++; if (perf_bc_cnt !== 32'd2 || perf_uop_cnt !== 32'd4) begin bad++; $display("FAIL perf_cnt: got %0d/%0d want 2/4", perf_bc_cnt, perf_uop_cnt); end
    perf_clr = 1'b1; @(negedge clk); perf_clr = 1'b0;
    total++; if (perf_bc_cnt !== 32'd0 || perf_uop_cnt !== 32'd0) begin bad++; $display("FAIL perf_clr1: got %0d/%0d want 0/0", perf_bc_cnt, perf_uop_cnt); end
  endtask
`endif

  task automatic test_reset_mid();
    logic [23:0] got, want;
    bit saw_done;
    int n;
    n = 0; saw_done = 1'b0;
    bus.bc_valid = 1'b1; bus.bc_opcode = 8'h60; bus.uop_ready = 1'b0;
    @(negedge clk);
    bus.bc_valid = 1'b0;
    while (!bus.uop_valid && n < 10) begin @(negedge clk); n++; end
    total++; if (bus.uop_valid !== 1'b1 || bus.uop_adr !== 9'd256) begin bad++; $display("FAIL rstmid_setup: got valid=%0b adr=%0d want 1/256", bus.uop_valid, bus.uop_adr); end
    rst_n = 1'b0;
    #1;
    want = {1'b1, 1'b0, 9'd0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0};
    got  = {bus.bc_ready, bus.uop_valid, bus.uop_adr, done, trap, trap_code, trap_opcode, busy};
    total++; if (got !== want) begin bad++; $display("FAIL rstmid_vals: got %h want %h", got, want); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); if (done) saw_done = 1'b1; end
    total++; if (saw_done !== 1'b0) begin bad++; $display("FAIL rstmid_nodone: got %0b want 0", saw_done); end
    run_op(8'h64, 100, 50);
    total++; if (got_done !== 1'b1 || obs_q.size() !== 2) begin bad++; $display("FAIL rstmid_fresh: got done=%0b len=%0d want 1/2", got_done, obs_q.size()); end
    else begin
      total++; if (obs_q[0] !== 9'd258 || obs_q[1] !== 9'd257) begin bad++; $display("FAIL rstmid_seq: got %0d,%0d want 258,257", obs_q[0], obs_q[1]); end
    end
  endtask

  task automatic test_random();
    logic [7:0] opc;
    int r, m;
    for (int it = 0; it < 40; it++) begin
      for (int a = 9'h180; a < 9'h1FF; a++) begin
        r = $urandom_range(0, 99);
        rom_mem[a] = (r < 25) ? 9'd0 : (r < 28) ? 9'h1FF : 9'(9'h180 + $urandom_range(0, 126));
      end
      opc = 8'(8'h80 + $urandom_range(0, 127));
      r = $urandom_range(0, 99);
      rom_mem[{1'b0, opc}] = (r < 5) ? 9'd0 : (r < 10) ? 9'h1FF : 9'(9'h180 + $urandom_range(0, 126));
      model_walk(opc);
      run_op(opc, $urandom_range(30, 100), 3000);
      total++; if (timeout !== 1'b0 || got_done !== exp_done) begin bad++; $display("FAIL rnd_outcome[%0d]: got done=%0b timeout=%0b want done=%0b", it, got_done, timeout, exp_done); end
      total++; if (obs_q.size() !== exp_q.size()) begin bad++; $display("FAIL rnd_len[%0d]: got %0d want %0d", it, obs_q.size(), exp_q.size()); end
      m = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int k = 0; k < m; k++) begin
        total++; if (obs_q[k] !== exp_q[k]) begin bad++; $display("FAIL rnd_adr[%0d.%0d]: got %0d want %0d", it, k, obs_q[k], exp_q[k]); end
      end
      total++; if (stall_bad !== 0 || bad_adr !== 0) begin bad++; $display("FAIL rnd_stable[%0d]: got unstable=%0d badadr=%0d want 0/0", it, stall_bad, bad_adr); end
      if (!exp_done) begin
        total++; if (trap_code !== exp_code || trap_opcode !== opc) begin bad++; $display("FAIL rnd_trap[%0d]: got code=%0d opc=%h want %0d/%h", it, trap_code, trap_opcode, exp_code, opc); end
      end
      if (got_trap) clear_trap();
    end
  endtask

  initial begin
    rst_n = 1'b0; trap_clr = 1'b0;
    bus.bc_valid = 1'b0; bus.bc_opcode = 8'h00; bus.uop_ready = 1'b0;
`ifdef MICRO_SEQUENCER_PERF_EN
    perf_clr = 1'b0;
`endif
    for (int a = 0; a < 512; a++) rom_mem[a] = 9'd0;
    rom_mem[9'h060] = 9'd256; rom_mem[9'd256] = 9'd257; rom_mem[9'd257] = 9'd0;
    rom_mem[9'h064] = 9'd258; rom_mem[9'd258] = 9'd257;
    repeat (2) @(negedge clk);
    test_reset();
    test_iadd();
    test_isub_stall();
    test_unsup();
    test_badrom();
    test_steps();
`ifdef MICRO_SEQUENCER_PERF_EN
    test_perf();
`endif
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
- Microcode sequencer for the bytecode-to-ARM translation pipeline.
- Accepts one JVM opcode per transaction and dispatches it through the external combinational next-address ROM (opcode in, microaddress out).
- Walks the microaddress chain, presenting one microaddress per cycle to the downstream micro-op emitter under valid/ready, until the chain terminates.
- Flags unsupported opcodes, invalid ROM entries and runaway chains as traps.

Parameters:
- ADR_W, 9, width of ROM address/data and microaddress.
- OPC_W, 8, bytecode opcode width; must satisfy OPC_W < ADR_W.
- MAX_STEPS, 32, maximum microaddresses per opcode before trapping.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- bc_valid  in  1  opcode offered.
- bc_ready  out  1  sequencer accepts an opcode.
- bc_opcode  in  OPC_W  JVM opcode.
- rom_adr  out  ADR_W  address to next-address ROM.
- rom_next  in  ADR_W  ROM output, combinational from rom_adr.
- uop_valid  out  1  microaddress available.
- uop_ready  in  1  emitter consumes the microaddress.
- uop_adr  out  ADR_W  current microaddress (uPC).
- done  out  1  one-cycle pulse when an opcode's chain completes.
- trap  out  1  sticky error flag.
- trap_code  out  2  cause: 1 = unsupported opcode, 2 = invalid ROM entry (all ones), 3 = step limit.
- trap_opcode  out  OPC_W  opcode that trapped.
- trap_clr  in  1  clears the trap and returns to IDLE.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (async, rst_n low) values: state=IDLE, bc_ready=1, uop_valid=0, uop_adr=0, done=0, trap=0, trap_code=0, trap_opcode=0, busy=0, step counter=0.
- rom_adr is combinational from registered state only; it never depends on bc_opcode directly.
  - DISPATCH: rom_adr = zero-extended latched opcode.
  - RUN: rom_adr = uPC.
  - Otherwise: rom_adr = 0.
- States: IDLE, DISPATCH, RUN, TRAP.
- IDLE: bc_ready=1.
  - On bc_valid & bc_ready: latch the opcode, clear the step counter, go to DISPATCH.
- DISPATCH (1 cycle): sample rom_next.
  - rom_next==0 -> TRAP, code 1.
  - rom_next all ones -> TRAP, code 2.
  - Otherwise uPC <= rom_next, go to RUN.
- RUN: uop_valid=1, uop_adr=uPC. Nothing changes while uop_ready=0; uop_adr stays stable under backpressure.
- On uop_valid & uop_ready in RUN, evaluate in this priority order:
  1. rom_next==0: pulse done next cycle, go to IDLE.
  2. rom_next all ones: TRAP, code 2.
  3. step counter == MAX_STEPS-1: TRAP, code 3.
  4. Otherwise: uPC <= rom_next, increment the step counter.
- Latency: opcode accepted at cycle N -> first uop_valid at N+2.
  - Each further microaddress costs 1 cycle with uop_ready held high.
  - Final handshake at cycle M -> done=1 and bc_ready=1 at M+1.
  - Next opcode can be accepted at M+1.
- TRAP: trap=1, bc_ready=0, uop_valid=0; trap_code and trap_opcode are held.
  - trap_clr -> IDLE, trap fields cleared, next cycle.
  - trap_clr is ignored in all other states.
- The microaddress handed downstream is never 0 and never all ones.
- Reset asserted mid-operation aborts immediately to reset values; no done pulse is issued.
- The step counter is wide enough for MAX_STEPS (clog2) and saturates at the limit, never wrapping.

Optional Feature:
- Macro: MICRO_SEQUENCER_PERF_EN.
- When defined: adds outputs perf_bc_cnt (32) and perf_uop_cnt (32) and input perf_clr (1).
  - perf_bc_cnt counts each done pulse.
  - perf_uop_cnt counts each uop handshake.
  - Both wrap at 2^32, clear on reset or perf_clr, and perf_clr takes priority over a same-cycle increment.
- When undefined: these ports and registers are absent; all other behaviour is identical.

Decomposition:
- Shared package micro_seq_pkg holds:
  - the state enum (IDLE, DISPATCH, RUN, TRAP);
  - trap code constants (TRAP_NONE=0, TRAP_UNSUP=1, TRAP_BADROM=2, TRAP_STEPS=3);
  - UADR_END=0;
  - UADR_INVALID = all ones.
- One natural sub-module: micro_seq_step_cnt (saturating step counter with limit compare).
- The ROM itself stays external.

Test Plan:
- iadd 0x60 with uop_ready=1 -> uop_adr 256 then 257, done pulse, bc_ready back at cycle N+4.
- isub 0x64 with uop_ready toggling 0/1 -> uop_adr 258 held stable while stalled, then 257, then done; no microaddress dropped.
- Opcode 0x00 (ROM returns 0) -> trap=1, trap_code=1, trap_opcode=0x00, no uop_valid; trap_clr -> IDLE.
- ROM model returns all ones for 0x60 -> trap_code=2; a self-loop 256->256 -> trap_code=3 after exactly 32 uops.
- rst_n asserted while uop_adr=256 -> all outputs at reset values immediately; no done pulse; a fresh 0x64 then sequences normally.
- With MICRO_SEQUENCER_PERF_EN: run iadd then isub -> perf_bc_cnt=2, perf_uop_cnt=4; perf_clr -> both 0.
